// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: FSM encoding, MEM/WB bundle and bubble.
// Imported by mem_wb_register and mem_access_stage.
package mem_access_stage_pkg;

   localparam int PKG_DATA_W = 32;
   localparam int PKG_REG_W  = 5;

   localparam logic [0:0] MEM_IDLE = 1'b0;
   localparam logic [0:0] MEM_BUSY = 1'b1;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [PKG_DATA_W-1:0] read_data;
      logic [PKG_DATA_W-1:0] alu_result;
      logic [PKG_REG_W-1:0]  rd;
   } mem_wb_t;

   localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage_mem_wb_register.sv
// MEM/WB pipeline register with load and bubble-insert controls.
// Ports: clk, reset (async, high), load, bubble, d (next bundle), q.
module mem_wb_register
   import mem_access_stage_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    load,
   input  logic    bubble,
   input  mem_wb_t d,
   output mem_wb_t q
);

   // bubble wins over load so a dropped instruction never leaks through
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= MEM_WB_BUBBLE;
      end else if (bubble) begin
         q <= MEM_WB_BUBBLE;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: multi-cycle dmem req/ack, upstream stall, MEM/WB register.
// Ports: EX/MEM inputs, dmem_* request bus, stall/error pulses, MEM/WB outs.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W      = PKG_DATA_W,
   parameter int REG_W       = PKG_REG_W,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              MemToReg_in,
   input  logic              RegWrite_in,
   input  logic [DATA_W-1:0] ALUResult_in,
   input  logic [DATA_W-1:0] RD2_in,
   input  logic [REG_W-1:0]  Rd_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic              misalign_err,
   output logic              timeout_err,
   output logic              RegWrite_out,
   output logic              MemToReg_out,
   output logic [DATA_W-1:0] ReadData_out,
   output logic [DATA_W-1:0] ALUResult_out,
   output logic [REG_W-1:0]  Rd_out
);

   localparam int CNT_W =
      (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             mem_op;
   logic             misaligned;
   logic             timeout_hit;
   logic             wb_load;
   mem_wb_t          wb_d;
   mem_wb_t          wb_q;

   assign mem_op      = MemRead_in | MemWrite_in;
   assign misaligned  = mem_op & (ALUResult_in[1:0] != 2'b00);
   assign timeout_hit = ~dmem_ack & (cnt == CNT_MAX);
   assign dmem_req    = (state == MEM_BUSY);

   always_comb begin
      stall        = 1'b0;
      misalign_err = 1'b0;
      timeout_err  = 1'b0;
      wb_load      = 1'b0;
      unique case (state)
         MEM_IDLE: begin
            misalign_err = misaligned;
            stall        = mem_op & ~misaligned;
            wb_load      = ~mem_op;
         end
         MEM_BUSY: begin
            timeout_err = timeout_hit;
            stall       = ~dmem_ack & ~timeout_hit;
            wb_load     = dmem_ack;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= MEM_IDLE;
         cnt        <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         unique case (state)
            MEM_IDLE: begin
               if (mem_op && !misaligned) begin
                  state      <= MEM_BUSY;
                  cnt        <= '0;
                  dmem_we    <= MemWrite_in;
                  dmem_addr  <= ALUResult_in;
                  dmem_wdata <= RD2_in;
               end
            end
            MEM_BUSY: begin
               if (dmem_ack || timeout_hit) begin
                  state <= MEM_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      wb_d            = MEM_WB_BUBBLE;
      wb_d.reg_write  = RegWrite_in;
      wb_d.mem_to_reg = MemToReg_in;
      wb_d.alu_result = ALUResult_in;
      wb_d.rd         = Rd_in;
      if (state == MEM_BUSY && dmem_ack) begin
         wb_d.read_data = dmem_rdata;
      end
   end

   mem_wb_register u_mem_wb (
      .clk    (clk),
      .reset  (reset),
      .load   (wb_load),
      .bubble (~wb_load),
      .d      (wb_d),
      .q      (wb_q)
   );

   assign RegWrite_out  = wb_q.reg_write;
   assign MemToReg_out  = wb_q.mem_to_reg;
   assign ReadData_out  = wb_q.read_data;
   assign ALUResult_out = wb_q.alu_result;
   assign Rd_out        = wb_q.rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed vectors, queued
// MEM/WB expectations popped by a monitor on every non-bubble output.
module tb_mem_access_stage;

   typedef struct packed {
      logic        rw;
      logic        mtr;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
   } wb_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in;
   logic [31:0] ALUResult_in, RD2_in;
   logic [4:0]  Rd_in;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        stall, misalign_err, timeout_err;
   logic        RegWrite_out, MemToReg_out;
   logic [31:0] ReadData_out, ALUResult_out;
   logic [4:0]  Rd_out;

   int  total = 0;
   int  bad   = 0;
   wb_t exp_q[$];

   mem_access_stage #(
      .DATA_W(32), .REG_W(5), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .reset(reset),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
      .ALUResult_in(ALUResult_in), .RD2_in(RD2_in), .Rd_in(Rd_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .misalign_err(misalign_err),
      .timeout_err(timeout_err),
      .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
      .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
      .Rd_out(Rd_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic mr, input logic mw,
                        input logic mtr, input logic rw,
                        input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [4:0] rd);
      MemRead_in   = mr;
      MemWrite_in  = mw;
      MemToReg_in  = mtr;
      RegWrite_in  = rw;
      ALUResult_in = alu;
      RD2_in       = rd2;
      Rd_in        = rd;
   endtask

   task automatic idle_in();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
   endtask

   // monitor: any non-bubble MEM/WB content must match the queue head
   wb_t act_wb;
   wb_t exp_wb;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         act_wb = '{RegWrite_out, MemToReg_out, ReadData_out,
                    ALUResult_out, Rd_out};
         if (!reset && act_wb != '0) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL wb_unexpected: got %h want none", act_wb);
            end else begin
               exp_wb = exp_q.pop_front();
               if (act_wb !== exp_wb) begin
                  bad++;
                  $display("FAIL wb_data: got %h want %h",
                           act_wb, exp_wb);
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      idle_in();
      #2;
      chk("rst_req", {31'h0, dmem_req}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wb_rw", {31'h0, RegWrite_out}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // 1: ALU-only instruction
      @(negedge clk);
      drive(0, 0, 0, 1, 32'h1234, 32'h0, 5'd5);
      exp_q.push_back('{1'b1, 1'b0, 32'h0, 32'h1234, 5'd5});
      #2 chk("alu_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      idle_in();
      chk("alu_rd_out", {27'h0, Rd_out}, 32'd5);

      // 2: load 0x100, ack on the 3rd BUSY cycle
      @(negedge clk);
      drive(1, 0, 1, 1, 32'h100, 32'h0, 5'd7);
      exp_q.push_back('{1'b1, 1'b1, 32'hDEADBEEF, 32'h100, 5'd7});
      #2;
      chk("ld_idle_stall", {31'h0, stall}, 32'h1);
      chk("ld_idle_req", {31'h0, dmem_req}, 32'h0);
      @(negedge clk);
      #2;
      chk("ld_b1_req", {31'h0, dmem_req}, 32'h1);
      chk("ld_b1_addr", dmem_addr, 32'h100);
      chk("ld_b1_we", {31'h0, dmem_we}, 32'h0);
      chk("ld_b1_stall", {31'h0, stall}, 32'h1);
      chk("ld_b1_bubble", {31'h0, RegWrite_out}, 32'h0);
      @(negedge clk);
      #2 chk("ld_b2_stall", {31'h0, stall}, 32'h1);
      @(negedge clk);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEADBEEF;
      #2 chk("ld_b3_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      idle_in();
      chk("ld_done_rdata", ReadData_out, 32'hDEADBEEF);
      #2 chk("ld_done_req", {31'h0, dmem_req}, 32'h0);

      // 3: store 0xCAFE0001 to 0x200, ack on 1st BUSY cycle
      @(negedge clk);
      drive(0, 1, 0, 0, 32'h200, 32'hCAFE0001, 5'd0);
      exp_q.push_back('{1'b0, 1'b0, 32'h11111111, 32'h200, 5'd0});
      #2 chk("st_idle_stall", {31'h0, stall}, 32'h1);
      @(negedge clk);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h11111111;
      #2;
      chk("st_we", {31'h0, dmem_we}, 32'h1);
      chk("st_wdata", dmem_wdata, 32'hCAFE0001);
      chk("st_addr", dmem_addr, 32'h200);
      chk("st_b1_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      idle_in();
      chk("st_rw_out", {31'h0, RegWrite_out}, 32'h0);

      // 4: misaligned load from 0x102
      @(negedge clk);
      drive(1, 0, 1, 1, 32'h102, 32'h0, 5'd9);
      #2;
      chk("mis_err", {31'h0, misalign_err}, 32'h1);
      chk("mis_stall", {31'h0, stall}, 32'h0);
      chk("mis_req", {31'h0, dmem_req}, 32'h0);
      @(negedge clk);
      idle_in();
      #2;
      chk("mis_err_clr", {31'h0, misalign_err}, 32'h0);
      chk("mis_req_after", {31'h0, dmem_req}, 32'h0);
      chk("mis_bubble_alu", ALUResult_out, 32'h0);
      chk("mis_bubble_rw", {31'h0, RegWrite_out}, 32'h0);

      // 5: load with no ack -> timeout in the 16th BUSY cycle
      @(negedge clk);
      drive(1, 0, 1, 1, 32'h300, 32'h0, 5'd3);
      #2 chk("to_idle_stall", {31'h0, stall}, 32'h1);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         #2;
         chk("to_busy_stall", {31'h0, stall}, 32'h1);
         chk("to_busy_err", {31'h0, timeout_err}, 32'h0);
      end
      @(negedge clk);
      #2;
      chk("to_err", {31'h0, timeout_err}, 32'h1);
      chk("to_stall_drop", {31'h0, stall}, 32'h0);
      chk("to_req_last", {31'h0, dmem_req}, 32'h1);
      @(negedge clk);
      idle_in();
      #2;
      chk("to_req_after", {31'h0, dmem_req}, 32'h0);
      chk("to_err_clr", {31'h0, timeout_err}, 32'h0);
      chk("to_no_wb", {31'h0, RegWrite_out}, 32'h0);

      // 6: reset in the 2nd BUSY cycle
      @(negedge clk);
      drive(1, 0, 1, 1, 32'h400, 32'h0, 5'd4);
      @(negedge clk);
      @(negedge clk);
      #2;
      chk("rb_req_pre", {31'h0, dmem_req}, 32'h1);
      chk("rb_addr_pre", dmem_addr, 32'h400);
      reset = 1'b1;
      #1;
      chk("rb_req", {31'h0, dmem_req}, 32'h0);
      chk("rb_addr", dmem_addr, 32'h0);
      chk("rb_we", {31'h0, dmem_we}, 32'h0);
      chk("rb_wdata", dmem_wdata, 32'h0);
      chk("rb_wb_rw", {31'h0, RegWrite_out}, 32'h0);
      chk("rb_wb_alu", ALUResult_out, 32'h0);
      chk("rb_terr", {31'h0, timeout_err}, 32'h0);
      idle_in();
      #1 chk("rb_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #2;
      chk("rb_rel_req", {31'h0, dmem_req}, 32'h0);
      chk("rb_rel_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      drive(0, 0, 0, 1, 32'h55AA, 32'h0, 5'd12);
      exp_q.push_back('{1'b1, 1'b0, 32'h0, 32'h55AA, 5'd12});
      #2 chk("rb_alu_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      idle_in();
      repeat (3) @(negedge clk);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
